// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the PC mux.
package pipe_ctrl_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StExc     = 2'd2
    } ctrl_state_e;

    // Exception vector loaded into the PC when pc_sel_exc is high.
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    // Bundle of all pipeline-register controls driven by the controller.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
        logic pc_sel_exc;
    } ctrl_t;

    // Free-running pipeline: everything advances, nothing flushed.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c.pc_en       = 1'b1;
        c.ifid_en     = 1'b1;
        c.idex_en     = 1'b1;
        c.exmem_en    = 1'b1;
        c.memwb_en    = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_flush  = 1'b0;
        c.exmem_flush = 1'b0;
        c.memwb_flush = 1'b0;
        c.pc_sel_exc  = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID instruction.
module hazard_detect (
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    output logic       load_use
);

    // $zero never carries a dependency, so a load into r0 cannot stall.
    always_comb begin
        load_use = idex_mem_read && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory waits with timeout,
// exception redirection, branch/jump flushes and load-use stalls.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             exc_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_sel_exc,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [8:0] TimeoutCnt = 9'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             exc_pending_q, exc_pending_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             load_use;
    logic             mem_stall;
    logic [8:0]       wait_inc;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .load_use      (load_use)
    );

    // Priority resolution and next-state logic; outputs depend on state and live inputs.
    always_comb begin
        ctrl          = ctrl_default();
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        exc_pending_d = exc_pending_q;
        bus_err_d     = 1'b0;
        wait_inc      = {1'b0, wait_cnt_q} + 9'd1;
        mem_stall     = ((state_q == StRun) && mem_req && !mem_ready) ||
                        ((state_q == StMemWait) && !mem_ready);

        if (reset) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_en    = 1'b0;
            ctrl.memwb_en    = 1'b0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else begin
            case (state_q)
                StRun, StMemWait: begin
                    if (mem_stall) begin
                        // Freeze everything upstream of MEM; WB receives bubbles.
                        ctrl.pc_en       = 1'b0;
                        ctrl.ifid_en     = 1'b0;
                        ctrl.idex_en     = 1'b0;
                        ctrl.exmem_en    = 1'b0;
                        ctrl.memwb_flush = 1'b1;
                        // Exceptions arriving during a wait are deferred until it ends.
                        exc_pending_d    = exc_pending_q | exc_req;
                        if (wait_inc == TimeoutCnt) begin
                            state_d    = StExc;
                            wait_cnt_d = 8'd0;
                            bus_err_d  = 1'b1;
                        end else begin
                            state_d    = StMemWait;
                            wait_cnt_d = wait_inc[7:0];
                        end
                    end else if (state_q == StMemWait) begin
                        // Access completed: release with default controls.
                        state_d       = StRun;
                        wait_cnt_d    = 8'd0;
                        exc_pending_d = exc_pending_q | exc_req;
                    end else if (exc_req || exc_pending_q) begin
                        ctrl.pc_sel_exc  = 1'b1;
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_flush  = 1'b1;
                        ctrl.exmem_flush = 1'b1;
                        exc_pending_d    = 1'b0;
                    end else if (ex_branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, insert a bubble into EX; a jump in ID retries.
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (id_jump) begin
                        ctrl.ifid_flush = 1'b1;
                    end
                end
                StExc: begin
                    ctrl.pc_sel_exc  = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_flush = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                    state_d          = StRun;
                    wait_cnt_d       = 8'd0;
                    exc_pending_d    = 1'b0;
                end
                default: begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // State, wait counter, deferred exception flag and bus-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            wait_cnt_q    <= 8'd0;
            exc_pending_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            exc_pending_q <= exc_pending_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign pc_sel_exc  = ctrl.pc_sel_exc;
    assign bus_err     = bus_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
